// File: rtl/fp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fp_pkg                                                                |
// | Shared widths, FSM states and field helpers for the fp accumulator.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package fp_pkg;

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_DRAIN = 2'd1,
    S_NORM  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  function automatic int sig_width(input int fs, input int es);
    return fs - es - 1;
  endfunction

  function automatic int exp_bias(input int es);
    return (1 << (es - 1)) - 1;
  endfunction

  // Signed width of one beat's lane sum: hidden bit + frac + guard + lane growth + sign.
  function automatic int beat_width(input int sig, input int guard, input int lanes);
    return sig + 1 + guard + $clog2(lanes) + 1;
  endfunction

  function automatic int acc_width(input int sig, input int guard, input int lanes,
                                   input int max_beats);
    return sig + 2 + guard + $clog2(lanes) + $clog2(max_beats) + 1;
  endfunction

  function automatic logic [31:0] fp_field(input logic [63:0] f, input int lsb,
                                           input int width);
    return 32'((f >> lsb) & ((64'd1 << width) - 64'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lane_align_sum.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fp_lane_align_sum                                                     |
// | Aligns LANES floats to their largest exponent and sums them signed.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fp_lane_align_sum
  import fp_pkg::*;
#(
  parameter int FLOATSIZE    = 16,
  parameter int EXPONENTSIZE = 5,
  parameter int LANES        = 4,
  parameter int GUARD        = 3
) (
  input  logic [LANES-1:0][FLOATSIZE-1:0]                       in_data,
  output logic [EXPONENTSIZE-1:0]                               beat_exp,
  output logic signed [beat_width(sig_width(FLOATSIZE, EXPONENTSIZE), GUARD, LANES)-1:0] beat_mant
);

  localparam int c_sig  = sig_width(FLOATSIZE, EXPONENTSIZE);
  localparam int c_mw   = 1 + c_sig + GUARD;
  localparam int c_bw   = beat_width(c_sig, GUARD, LANES);

  logic [LANES-1:0][EXPONENTSIZE-1:0] w_exp;
  logic [LANES-1:0][c_mw-1:0]         w_sig;
  logic [LANES-1:0]                   w_neg;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_exp[g] = EXPONENTSIZE'(fp_field(64'(in_data[g]), c_sig, EXPONENTSIZE));
    assign w_sig[g] = {1'b1, in_data[g][c_sig-1:0], {GUARD{1'b0}}};
    assign w_neg[g] = in_data[g][FLOATSIZE-1];
  end

  // A zero exponent field never wins the max, so zero lanes cannot set beat_exp.
  always_comb begin
    beat_exp = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_exp[i] > beat_exp) beat_exp = w_exp[i];
    end
  end

  always_comb begin
    beat_mant = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_exp[i] != '0) begin
        if (w_neg[i])
          beat_mant = beat_mant - ({{(c_bw-c_mw){1'b0}}, w_sig[i]} >> (beat_exp - w_exp[i]));
        else
          beat_mant = beat_mant + ({{(c_bw-c_mw){1'b0}}, w_sig[i]} >> (beat_exp - w_exp[i]));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_accum_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fp_accum_stream                                                       |
// | Streaming multi-beat float accumulator with RNE normalise/round.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fp_accum_stream
  import fp_pkg::*;
#(
  parameter int FLOATSIZE    = 16,
  parameter int EXPONENTSIZE = 5,
  parameter int LANES        = 4,
  parameter int GUARD        = 3,
  parameter int MAX_BEATS    = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES-1:0][FLOATSIZE-1:0]      in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [FLOATSIZE-1:0]                 out_data,
  output logic [$clog2(MAX_BEATS+1)-1:0]       out_count,
  output logic                                 out_overflow
);

  localparam int c_sig    = sig_width(FLOATSIZE, EXPONENTSIZE);
  localparam int c_beat_w = beat_width(c_sig, GUARD, LANES);
  localparam int c_acc_w  = acc_width(c_sig, GUARD, LANES, MAX_BEATS);
  localparam int c_cnt_w  = $clog2(MAX_BEATS + 1);
  localparam int c_lead_w = $clog2(c_acc_w);
  localparam int c_xw     = EXPONENTSIZE + c_lead_w + 2;
  localparam logic [c_lead_w-1:0] c_msb = c_lead_w'(c_acc_w - 1);

  state_t                       r_state, w_next;
  logic                         w_accept;
  logic [EXPONENTSIZE-1:0]      w_lane_exp;
  logic signed [c_beat_w-1:0]   w_lane_mant;

  logic                         r_s1_valid;
  logic [EXPONENTSIZE-1:0]      r_s1_exp;
  logic signed [c_beat_w-1:0]   r_s1_mant;

  logic [EXPONENTSIZE-1:0]      r_acc_exp, w_sum_exp;
  logic signed [c_acc_w-1:0]    r_acc_mant, w_sum_mant, w_beat_ext;
  logic [c_cnt_w-1:0]           r_count;
  logic                         r_cnt_ovf;

  logic                         w_neg, w_round_up, w_exp_ovf;
  logic [c_acc_w-1:0]           w_mag, w_norm;
  logic [c_lead_w-1:0]          w_lead;
  logic [c_sig:0]               w_frac_rnd;
  logic signed [c_xw-1:0]       w_res_exp;
  logic [FLOATSIZE-1:0]         w_res_data;

  logic [FLOATSIZE-1:0]         r_out_data;
  logic [c_cnt_w-1:0]           r_out_count;
  logic                         r_out_ovf;

  fp_lane_align_sum #(
    .FLOATSIZE    (FLOATSIZE),
    .EXPONENTSIZE (EXPONENTSIZE),
    .LANES        (LANES),
    .GUARD        (GUARD)
  ) u_align (
    .in_data   (in_data),
    .beat_exp  (w_lane_exp),
    .beat_mant (w_lane_mant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ACC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_NORM;
      S_NORM:  w_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_ACC;
      end
      default: w_next = S_ACC;
    endcase
  end

  assign w_accept   = in_valid && in_ready;
  assign w_beat_ext = {{(c_acc_w-c_beat_w){r_s1_mant[c_beat_w-1]}}, r_s1_mant};

  // A zero operand contributes neither value nor exponent to the alignment.
  always_comb begin
    w_sum_exp  = r_acc_exp;
    w_sum_mant = r_acc_mant;
    if (r_s1_valid && w_beat_ext != '0) begin
      if (r_acc_mant == '0) begin
        w_sum_exp  = r_s1_exp;
        w_sum_mant = w_beat_ext;
      end else if (r_s1_exp > r_acc_exp) begin
        w_sum_exp  = r_s1_exp;
        w_sum_mant = (r_acc_mant >>> (r_s1_exp - r_acc_exp)) + w_beat_ext;
      end else begin
        w_sum_mant = r_acc_mant + (w_beat_ext >>> (r_acc_exp - r_s1_exp));
      end
    end
  end

  // Normalise so the leading one lands in the MSB; bits below the kept
  // fraction become round (first) and sticky (rest).
  always_comb begin
    w_neg  = r_acc_mant[c_acc_w-1];
    w_mag  = w_neg ? -r_acc_mant : r_acc_mant;
    w_lead = '0;
    for (int i = 0; i < c_acc_w; i++) begin
      if (w_mag[i]) w_lead = c_lead_w'(i);
    end
    w_norm     = w_mag << (c_msb - w_lead);
    w_round_up = w_norm[c_acc_w-2-c_sig] &&
                 ((|w_norm[c_acc_w-3-c_sig:0]) || w_norm[c_acc_w-1-c_sig]);
    w_frac_rnd = {1'b0, w_norm[c_acc_w-2 -: c_sig]} + {{c_sig{1'b0}}, w_round_up};
    w_res_exp  = $signed({{(c_xw-EXPONENTSIZE){1'b0}}, r_acc_exp})
               + $signed({{(c_xw-c_lead_w){1'b0}}, w_lead})
               + $signed({{(c_xw-1){1'b0}}, w_frac_rnd[c_sig]})
               - $signed(c_xw'(c_sig + GUARD));
    w_exp_ovf  = 1'b0;
    w_res_data = '0;
    if (w_norm[c_acc_w-1]) begin
      if (w_res_exp > $signed(c_xw'((1 << EXPONENTSIZE) - 1))) begin
        w_exp_ovf  = 1'b1;
        w_res_data = {w_neg, {(FLOATSIZE-1){1'b1}}};
      end else if (w_res_exp >= $signed(c_xw'(1))) begin
        w_res_data = {w_neg, w_res_exp[EXPONENTSIZE-1:0], w_frac_rnd[c_sig-1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_mant   <= '0;
      r_acc_exp   <= '0;
      r_acc_mant  <= '0;
      r_count     <= '0;
      r_cnt_ovf   <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_exp  <= w_lane_exp;
        r_s1_mant <= w_lane_mant;
      end
      if (out_valid && out_ready) begin
        r_acc_exp  <= '0;
        r_acc_mant <= '0;
        r_count    <= '0;
        r_cnt_ovf  <= 1'b0;
      end else begin
        r_acc_exp  <= w_sum_exp;
        r_acc_mant <= w_sum_mant;
        if (w_accept) begin
          if (r_count == c_cnt_w'(MAX_BEATS)) r_cnt_ovf <= 1'b1;
          else                                r_count   <= r_count + c_cnt_w'(1);
        end
      end
      if (r_state == S_NORM) begin
        r_out_data  <= w_res_data;
        r_out_count <= r_count;
        r_out_ovf   <= w_exp_ovf | r_cnt_ovf;
      end
    end
  end

  assign out_data     = r_out_data;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp_accum_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fp_accum_stream                                                    |
// | Self-checking bench: directed cases plus randomized packets vs model. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_fp_accum_stream;

  localparam int LANES = 4;
  localparam int MAXB  = 256;

  typedef logic [15:0] beat_t [LANES];

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES-1:0][15:0] in_data = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [15:0]            out_data;
  logic [8:0]             out_count;
  logic                   out_overflow;

  int    checks = 0;
  int    errors = 0;
  beat_t pkt_q[$];

  fp_accum_stream #(
    .FLOATSIZE(16), .EXPONENTSIZE(5), .LANES(LANES), .GUARD(3), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic add_beat(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    beat_t bt;
    bt[0] = a; bt[1] = b; bt[2] = c; bt[3] = d;
    pkt_q.push_back(bt);
  endtask

  // Reference: floats as integers scaled by 2^-(10+3) relative to their exponent.
  task automatic model_packet(output logic [15:0] d, output int cnt, output bit ovf);
    longint acc, mag, q, rem, half, s, m;
    int ae, be, e, p, ex, sh;
    bit neg;
    acc = 0; ae = 0;
    foreach (pkt_q[b]) begin
      be = 0; s = 0;
      for (int l = 0; l < LANES; l++) begin
        e = int'(pkt_q[b][l][14:10]);
        if (e > be) be = e;
      end
      for (int l = 0; l < LANES; l++) begin
        e = int'(pkt_q[b][l][14:10]);
        if (e != 0) begin
          m = (1024 + longint'(pkt_q[b][l][9:0])) * 8;
          m = m >> (be - e);
          s = pkt_q[b][l][15] ? s - m : s + m;
        end
      end
      if (s != 0) begin
        if (acc == 0) begin acc = s; ae = be; end
        else if (be > ae) begin acc = (acc >>> (be - ae)) + s; ae = be; end
        else acc = acc + (s >>> (ae - be));
      end
    end
    cnt = (pkt_q.size() > MAXB) ? MAXB : pkt_q.size();
    ovf = pkt_q.size() > MAXB;
    neg = acc < 0;
    mag = neg ? -acc : acc;
    d = 16'h0000;
    if (mag != 0) begin
      p = 0;
      for (int i = 0; i < 40; i++) if (((mag >> i) & 1) != 0) p = i;
      ex = ae + p - 13;
      if (p > 10) begin
        sh = p - 10;
        q = mag >> sh;
        rem = mag - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q & 1) != 0)) q = q + 1;
      end else begin
        q = mag << (10 - p);
      end
      if (q == 2048) begin q = 1024; ex = ex + 1; end
      if (ex > 31) begin
        d = {neg, 15'h7FFF};
        ovf = 1'b1;
      end else if (ex >= 1) begin
        d = {neg, 5'(ex), 10'(q)};
      end
    end
  endtask

  task automatic send_beat(input beat_t b, input bit last, output bit ok);
    int t;
    in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) in_data[l] = b[l];
    in_last = last;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    ok = (in_ready === 1'b1);
    if (ok) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(input int delay, output logic [15:0] d, output logic [8:0] c,
                      output logic o, output bit got);
    int t;
    t = 0; got = 1'b0; d = 'x; c = 'x; o = 'x;
    while (out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (out_valid === 1'b1) begin
      got = 1'b1; d = out_data; c = out_count; o = out_overflow;
      repeat (delay) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic run_packet(input int gap, input int delay, output logic [15:0] d,
                            output logic [8:0] c, output logic o, output bit ok);
    bit s;
    ok = 1'b1;
    foreach (pkt_q[i]) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      send_beat(pkt_q[i], i == pkt_q.size() - 1, s);
      if (!s) ok = 1'b0;
    end
    recv(delay, d, c, o, s);
    if (!s) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset out_data: got %h expected 0000", out_data); end
    checks++; if (out_count !== 9'd0) begin errors++; $display("FAIL reset out_count: got %0d expected 0", out_count); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset out_overflow: got %b expected 0", out_overflow); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset idle: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_single_beat_latency();
    in_valid = 1'b1; in_last = 1'b1;
    for (int l = 0; l < LANES; l++) in_data[l] = 16'h3C00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL latency k: got valid=%b ready=%b expected 0/0", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL latency k+1: got valid=%b ready=%b expected 0/0", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency k+2 out_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 16'h4400) begin errors++; $display("FAIL single_beat data: got %h expected 4400", out_data); end
    checks++; if (out_count !== 9'd1 || out_overflow !== 1'b0) begin errors++; $display("FAIL single_beat count/ovf: got %0d/%b expected 1/0", out_count, out_overflow); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_beat release: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_two_beats();
    logic [15:0] d; logic [8:0] c; logic o; bit ok;
    pkt_q.delete();
    add_beat(16'h3C00, 16'h4000, 16'h3800, 16'h0000);
    add_beat(16'hBC00, 16'h0000, 16'h0000, 16'h0000);
    run_packet(0, 0, d, c, o, ok);
    checks++; if (!ok || d !== 16'h4100) begin errors++; $display("FAIL two_beats data: got %h expected 4100 (handshake ok=%0d)", d, ok); end
    checks++; if (c !== 9'd2 || o !== 1'b0) begin errors++; $display("FAIL two_beats count/ovf: got %0d/%b expected 2/0", c, o); end
  endtask

  task automatic test_flush_zero();
    logic [15:0] d; logic [8:0] c; logic o; bit ok;
    pkt_q.delete();
    add_beat(16'h3C00, 16'hBC00, 16'h0001, 16'h8000);
    run_packet(0, 0, d, c, o, ok);
    checks++; if (!ok || d !== 16'h0000) begin errors++; $display("FAIL flush_zero data: got %h expected 0000 (handshake ok=%0d)", d, ok); end
    checks++; if (c !== 9'd1 || o !== 1'b0) begin errors++; $display("FAIL flush_zero count/ovf: got %0d/%b expected 1/0", c, o); end
  endtask

  task automatic test_saturate();
    logic [15:0] d; logic [8:0] c; logic o; bit ok;
    pkt_q.delete();
    add_beat(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00);
    run_packet(0, 0, d, c, o, ok);
    checks++; if (!ok || d !== 16'h7FFF) begin errors++; $display("FAIL saturate data: got %h expected 7fff (handshake ok=%0d)", d, ok); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL saturate overflow: got %b expected 1", o); end
  endtask

  task automatic test_rounding();
    logic [15:0] d; logic [8:0] c; logic o; bit ok;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h3C02; exp_d[1] = 16'h4200; exp_d[2] = 16'h4202;
    for (int k = 0; k < 3; k++) begin
      pkt_q.delete();
      case (k)
        0: add_beat(16'h3C00, 16'h1400, 16'h1400, 16'h0000);
        1: add_beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h1400);
        default: add_beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h1A00);
      endcase
      run_packet(0, 0, d, c, o, ok);
      checks++; if (!ok || d !== exp_d[k]) begin errors++; $display("FAIL rounding case %0d: got %h expected %h", k, d, exp_d[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held, d; logic [8:0] c; logic o; bit ok; int t;
    pkt_q.delete();
    add_beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_beat(pkt_q[0], 1'b1, ok);
    t = 0;
    while (out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h4400) begin errors++; $display("FAIL backpressure first: got valid=%b data=%h expected 1/4400", out_valid, out_data); end
    held = out_data;
    in_valid = 1'b1; in_last = 1'b1;
    in_data[0] = 16'h4000; in_data[1] = 16'h0000; in_data[2] = 16'h0000; in_data[3] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin errors++; $display("FAIL backpressure hold %0d: got valid=%b data=%h ready=%b expected 1/%h/0", i, out_valid, out_data, in_ready, held); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL backpressure reopen: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL backpressure accept: got ready=%b expected 0", in_ready); end
    recv(0, d, c, o, ok);
    checks++; if (!ok || d !== 16'h4000 || c !== 9'd1) begin errors++; $display("FAIL backpressure second: got %h/%0d expected 4000/1", d, c); end
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] d; logic [8:0] c; logic o; bit ok, s;
    pkt_q.delete();
    add_beat(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    send_beat(pkt_q[0], 1'b0, s);
    send_beat(pkt_q[0], 1'b0, s);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset state: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset spurious out_valid: got %b expected 0", out_valid); end
    pkt_q.delete();
    add_beat(16'h3C00, 16'h3C00, 16'h0000, 16'h0000);
    run_packet(0, 0, d, c, o, ok);
    checks++; if (!ok || d !== 16'h4000 || c !== 9'd1 || o !== 1'b0) begin errors++; $display("FAIL mid_reset result: got %h/%0d/%b expected 4000/1/0", d, c, o); end
  endtask

  task automatic test_count_overflow();
    logic [15:0] d; logic [8:0] c; logic o; bit ok;
    pkt_q.delete();
    for (int i = 0; i < MAXB + 1; i++) add_beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    run_packet(0, 0, d, c, o, ok);
    checks++; if (!ok || d !== 16'h6404) begin errors++; $display("FAIL count_overflow data: got %h expected 6404", d); end
    checks++; if (c !== 9'd256 || o !== 1'b1) begin errors++; $display("FAIL count_overflow count/ovf: got %0d/%b expected 256/1", c, o); end
  endtask

  function automatic logic [15:0] rand_lane();
    logic [15:0] v;
    v = 16'($urandom());
    if ($urandom_range(0, 7) == 0) v[14:10] = 5'd0;
    else v[14:10] = 5'($urandom_range(8, 22));
    return v;
  endfunction

  task automatic test_random();
    logic [15:0] d, ed; logic [8:0] c; logic o; bit ok, eo; int ec, n;
    for (int k = 0; k < 40; k++) begin
      pkt_q.delete();
      n = (k % 10 == 9) ? $urandom_range(10, 20) : $urandom_range(1, 6);
      for (int i = 0; i < n; i++) add_beat(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      model_packet(ed, ec, eo);
      run_packet(2, $urandom_range(0, 3), d, c, o, ok);
      checks++; if (!ok || d !== ed || c !== 9'(ec) || o !== eo) begin errors++; $display("FAIL random pkt %0d: got %h/%0d/%b expected %h/%0d/%b", k, d, c, o, ed, ec, eo); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat_latency();
    test_two_beats();
    test_flush_zero();
    test_saturate();
    test_rounding();
    test_backpressure();
    test_reset_mid_packet();
    test_count_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_accum_stream.md
# fp_accum_stream

Streaming floating-point accumulator for the inference datapath. It reduces a packet of beats, each beat carrying LANES floats, to a single float. It is the sequential, multi-beat successor of the combinational lane adder: extended-precision accumulation, round-to-nearest-even, subnormal flush, overflow saturation and valid/ready flow control. It sits between the multiply array and the activation stage; one packet is one neuron's dot-product terms.

## Interface
- FLOATSIZE, 16: total float width.
- EXPONENTSIZE, 5: exponent field width; bias is 2^(EXPONENTSIZE-1)-1.
- LANES, 4: floats per input beat.
- GUARD, 3: extra LSBs kept below the significand during alignment.
- MAX_BEATS, 256: beats per packet with guaranteed headroom.

- clk  in  1  clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  [FLOATSIZE-1:0] x LANES  lane values.
- in_last  in  1  final beat of packet.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  FLOATSIZE  packet sum.
- out_count  out  $clog2(MAX_BEATS+1)  beats in packet, saturating at MAX_BEATS.
- out_overflow  out  1  exponent saturated, or beat count exceeded MAX_BEATS.

## Operation
- SIG = FLOATSIZE-EXPONENTSIZE-1.
- Lane is zero if its exponent field is 0 (subnormals and -0 flushed).
- An all-ones exponent is an ordinary finite value; there is no inf/NaN.
- **Stage 1 (beat reduce, registered):**
  - beat_exp = max exponent over nonzero lanes.
  - Each lane magnitude {1,frac,GUARD'0} is shifted right by beat_exp-e (truncated), then negated if the sign bit is set.
  - The signed sum is registered with beat_exp. An all-zero beat gives a zero contribution.
- **Stage 2 (accumulate):**
  - new_exp = max(acc_exp, beat_exp), ignoring zero operands.
  - The smaller operand is arithmetic-right-shifted by the difference; bits beyond the LSB are dropped.
  - acc_mant width W = SIG+2+GUARD+$clog2(LANES)+$clog2(MAX_BEATS)+1, signed.
- **Normalise/round:**
  - Take magnitude and sign of acc_mant. Find the leading one at position p.
  - Result exponent = acc_exp + p - (SIG+GUARD).
  - Keep SIG bits below p, rounding to nearest-even on the remaining bits; a rounding carry bumps the exponent.
  - Exponent > 2^EXPONENTSIZE-1: out_data = {sign, all-ones, all-ones}, out_overflow=1.
  - Exponent < 1: output zero.
  - Zero result: out_data = '0 (positive zero).
- **FSM:**
  - S_ACC: in_ready=1. A handshake with in_last goes to S_DRAIN.
  - S_DRAIN: in_ready=0; the stage-1 register folds into the accumulator. Next state S_NORM.
  - S_NORM: registers out_data, out_count and out_overflow. Next state S_OUT.
  - S_OUT: out_valid=1, outputs held stable. On handshake, clear acc/count/flags and go to S_ACC.
- Beat counter increments per accepted beat. At MAX_BEATS+1 it saturates and sets out_overflow.

## Timing
- Reset (async assert, sync release) values:
  - State S_ACC, in_ready=1, out_valid=0, out_data=0, out_count=0, out_overflow=0.
  - Accumulator and pipeline registers cleared.
- Throughput: one beat per cycle within a packet.
- Latency: a last-beat handshake at edge k gives out_valid high after edge k+2 (third cycle).
- in_ready is low from edge k until the cycle after the out handshake, so there is no packet overlap.
- out_ready low holds all outputs and in_ready=0 indefinitely.
- A single-beat packet (first beat has in_last) follows the same timing.
- in_valid is ignored while in_ready=0.
- Reset mid-packet discards all partial state; there is no spurious out_valid.

## Structure
- Package fp_pkg: SIG, bias and W computation functions; FSM state enum; the float field-extract function.
- Sub-module fp_lane_align_sum: the combinational stage-1 reduction of LANES floats into {beat_exp, signed mantissa}. It is instantiated once, ahead of the stage-1 register.
- Normalise/round stays in this module.

## Test plan
- One beat {0x3C00,0x3C00,0x3C00,0x3C00}, in_last -> out_data 0x4400, out_count 1, out_valid high after edge k+2, in_ready low until consumed.
- Beats {0x3C00,0x4000,0x3800,0x0000} then {0xBC00,0,0,0} with last -> 0x4100, out_count 2.
- One beat {0x3C00,0xBC00,0x0001,0x8000} -> 0x0000 (subnormal and -0 flushed, cancellation gives positive zero).
- One beat {0x7C00 x4} -> 0x7FFF, out_overflow 1.
- Rounding: {0x3C00,0x1400,0x1400,0} (1 + 2·2^-10·2^-...) -> RNE result matching the bit-exact model. Include one exact tie rounding to even.
- Backpressure plus reset:
  - Hold out_ready=0 for 5 cycles: out_data stable, in_ready 0; next packet accepted the cycle after handshake.
  - Pulse rst_n low after 2 beats of a packet, then send {0x3C00,0x3C00,0,0} last -> 0x4000, out_count 1.
